// File: rtl/carry_chain_bist_if.sv
// Connection between the carry-chain BIST initiator and the carry stages under test.
// The initiator drives per-stage a/b and the stage-0 carry-in, and observes every cout.
interface carry_chain_bist_if #(
    parameter int NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0] dut_a;
    logic [NUM_STAGES-1:0] dut_b;
    logic                  dut_cin;
    logic [NUM_STAGES-1:0] dut_cout;

    modport master (
        output dut_a,
        output dut_b,
        output dut_cin,
        input  dut_cout
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        input  dut_cin,
        output dut_cout
    );
endinterface

// File: rtl/carry_chain_bist.sv
// BIST initiator for the CLB carry chain: drives LFSR vectors, waits for the ripple
// to settle, and compares every stage's cout with a golden mux-chain model.
module carry_chain_bist #(
    parameter int          NUM_STAGES    = 4,
    parameter int          NUM_VECTORS   = 64,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    carry_chain_bist_if.master    chain,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_vec,
    output logic [NUM_STAGES-1:0] fail_mask
);
    localparam int          N           = NUM_STAGES;
    localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   lfsr_reg, lfsr_next;
    logic [15:0]   vec_cnt_reg, vec_cnt_next;
    logic [3:0]    settle_cnt_reg, settle_cnt_next;
    logic [N-1:0]  a_reg, a_next;
    logic [N-1:0]  b_reg, b_next;
    logic          cin_reg, cin_next;
    logic          pass_reg, pass_next;
    logic [15:0]   fail_vec_reg, fail_vec_next;
    logic [N-1:0]  fail_mask_reg, fail_mask_next;
    logic          load_vec;

    logic [31:0]   lfsr_step;
    logic [N-1:0]  carry;
    logic [N-1:0]  expected;
    logic [N-1:0]  mask;

    assign lfsr_step = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};

    // Golden ripple, built only from the registered stimulus so a broken chain cannot mask itself.
    assign carry[0] = cin_reg;
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_golden
            assign expected[gi] = carry[gi] ? b_reg[gi] : a_reg[gi];
            if (gi < N - 1) begin : g_link
                assign carry[gi+1] = expected[gi];
            end
        end
    endgenerate

    assign mask = expected ^ chain.dut_cout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            lfsr_reg       <= LFSR_SEED;
            vec_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            cin_reg        <= 1'b0;
            pass_reg       <= 1'b0;
            fail_vec_reg   <= '0;
            fail_mask_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            vec_cnt_reg    <= vec_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            cin_reg        <= cin_next;
            pass_reg       <= pass_next;
            fail_vec_reg   <= fail_vec_next;
            fail_mask_reg  <= fail_mask_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lfsr_next       = lfsr_reg;
        vec_cnt_next    = vec_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        cin_next        = cin_reg;
        pass_next       = pass_reg;
        fail_vec_next   = fail_vec_reg;
        fail_mask_next  = fail_mask_reg;
        load_vec        = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next      = APPLY;
                    lfsr_next       = LFSR_SEED;
                    vec_cnt_next    = '0;
                    settle_cnt_next = '0;
                    pass_next       = 1'b0;
                    fail_vec_next   = '0;
                    fail_mask_next  = '0;
                    load_vec        = 1'b1;
                end
            end
            APPLY: begin
                if (settle_cnt_reg == LAST_SETTLE) begin
                    settle_cnt_next = '0;
                    state_next      = CHECK;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 4'd1;
                end
            end
            CHECK: begin
                // Match is tested as mask == 0 so an unknown cout falls into the failure branch.
                if (mask == '0) begin
                    if (vec_cnt_reg == LAST_VEC) begin
                        state_next = DONE;
                        pass_next  = 1'b1;
                    end else begin
                        lfsr_next    = lfsr_step;
                        vec_cnt_next = vec_cnt_reg + 16'd1;
                        load_vec     = 1'b1;
                        state_next   = APPLY;
                    end
                end else begin
                    state_next     = DONE;
                    pass_next      = 1'b0;
                    fail_vec_next  = vec_cnt_reg;
                    fail_mask_next = mask;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load_vec) begin
            a_next   = lfsr_next[N-1:0];
            b_next   = lfsr_next[2*N-1:N];
            cin_next = lfsr_next[2*N];
        end
    end

    assign chain.dut_a   = a_reg;
    assign chain.dut_b   = b_reg;
    assign chain.dut_cin = cin_reg;

    assign busy      = (state_reg == APPLY) || (state_reg == CHECK);
    assign done      = (state_reg == DONE);
    assign pass      = done & pass_reg;
    assign fail_vec  = fail_vec_reg;
    assign fail_mask = fail_mask_reg;
endmodule

// File: tb/tb_carry_chain_bist.sv
// Bench for carry_chain_bist: an ideal chain with injectable stuck-at faults, a
// cycle-level expectation model checked every cycle, and directed literal checks.
module tb_carry_chain_bist;
    localparam int          N    = 4;
    localparam int          NV   = 64;
    localparam int          S    = 2;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic start_s = 1'b0;
    logic start_g = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- main DUT (defaults) ----------------
    carry_chain_bist_if #(.NUM_STAGES(N)) m_if ();
    logic busy, done, pass;
    logic [15:0] fail_vec;
    logic [N-1:0] fail_mask;
    logic [N-1:0] sa0 = '0;
    logic [N-1:0] sa1 = '0;

    carry_chain_bist #(.NUM_STAGES(N), .NUM_VECTORS(NV), .SETTLE_CYCLES(S), .LFSR_SEED(SEED)) u_main (
        .clk(clk), .reset_n(reset_n), .start(start), .chain(m_if.master),
        .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec), .fail_mask(fail_mask)
    );

    // ---------------- minimal configuration ----------------
    carry_chain_bist_if #(.NUM_STAGES(1)) s_if ();
    logic s_busy, s_done, s_pass;
    logic [15:0] s_fail_vec;
    logic [0:0] s_fail_mask;

    carry_chain_bist #(.NUM_STAGES(1), .NUM_VECTORS(1), .SETTLE_CYCLES(1), .LFSR_SEED(SEED)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start_s), .chain(s_if.master),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail_vec(s_fail_vec), .fail_mask(s_fail_mask)
    );

    // ---------------- seed chosen to give a=0101 b=0011 cin=1 ----------------
    carry_chain_bist_if #(.NUM_STAGES(N)) g_if ();
    logic g_busy, g_done, g_pass;
    logic [15:0] g_fail_vec;
    logic [N-1:0] g_fail_mask;

    carry_chain_bist #(.NUM_STAGES(N), .NUM_VECTORS(1), .SETTLE_CYCLES(2), .LFSR_SEED(32'h0000_0135)) u_gold (
        .clk(clk), .reset_n(reset_n), .start(start_g), .chain(g_if.master),
        .busy(g_busy), .done(g_done), .pass(g_pass), .fail_vec(g_fail_vec), .fail_mask(g_fail_mask)
    );

    // Behaviour of a carry chain: each stage passes b when carried in, else a.
    function automatic logic [N-1:0] ripple(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        logic c;
        logic [N-1:0] r;
        c = cin;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = c ? b[i] : a[i];
            c = r[i];
        end
        return r;
    endfunction

    assign m_if.dut_cout = (ripple(m_if.dut_a, m_if.dut_b, m_if.dut_cin) & ~sa0) | sa1;
    assign g_if.dut_cout = ripple(g_if.dut_a, g_if.dut_b, g_if.dut_cin);
    assign s_if.dut_cout = s_if.dut_cin ? s_if.dut_b : s_if.dut_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    logic [31:0] tbl [NV];
    bit          m_run = 1'b0;
    int          m_k = 0;
    int          m_end = 0;
    int          m_fail_idx = -1;
    logic [N-1:0] m_fail_mask = '0;

    function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [N-1:0] golden_of(input logic [31:0] l);
        return ripple(l[N-1:0], l[2*N-1:N], l[2*N]);
    endfunction

    task automatic plan_run();
        logic [N-1:0] e, o;
        m_fail_idx = -1;
        m_fail_mask = '0;
        for (int v = 0; v < NV; v++) begin
            e = golden_of(tbl[v]);
            o = (e & ~sa0) | sa1;
            if (e != o) begin
                m_fail_idx = v;
                m_fail_mask = e ^ o;
                break;
            end
        end
        m_end = ((m_fail_idx < 0) ? NV : m_fail_idx + 1) * (S + 1);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0;
            m_k = 0;
        end else if ((!m_run || m_k >= m_end) && start) begin
            m_run = 1'b1;
            m_k = 0;
            plan_run();
        end else if (m_run && m_k < m_end) begin
            m_k++;
        end
    end

    logic        e_busy, e_done, e_pass;
    logic [15:0] e_fv;
    logic [N-1:0] e_fm;
    logic [31:0] e_vec;

    always @(negedge clk) begin
        e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
        e_fv = '0; e_fm = '0; e_vec = '0;
        if (m_run) begin
            if (m_k < m_end) begin
                e_busy = 1'b1;
                e_vec = tbl[m_k / (S + 1)];
            end else begin
                e_done = 1'b1;
                e_pass = (m_fail_idx < 0);
                if (m_fail_idx >= 0) begin
                    e_fv = 16'(m_fail_idx);
                    e_fm = m_fail_mask;
                end
                e_vec = tbl[m_end / (S + 1) - 1];
            end
        end
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("pass", 32'(pass), 32'(e_pass));
        check("fail_vec", 32'(fail_vec), 32'(e_fv));
        check("fail_mask", 32'(fail_mask), 32'(e_fm));
        check("dut_a", 32'(m_if.dut_a), 32'(e_vec[N-1:0]));
        check("dut_b", 32'(m_if.dut_b), 32'(e_vec[2*N-1:N]));
        check("dut_cin", 32'(m_if.dut_cin), 32'(e_vec[2*N]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 1000; i++) begin
            if (done) break;
            if (busy) bc++;
            @(negedge clk);
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    int bc;

    initial begin
        tbl[0] = SEED;
        for (int v = 1; v < NV; v++) tbl[v] = lfsr_adv(tbl[v-1]);

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dut_a", 32'(m_if.dut_a), 32'd0);
        reset_n = 1'b1;

        // Ideal chain: 64 vectors x 3 cycles.
        start_pulse();
        wait_done(bc);
        check("ideal_busy_cycles", 32'(bc), 32'd192);
        check("ideal_pass", 32'(pass), 32'd1);
        check("ideal_fail_vec", 32'(fail_vec), 32'd0);
        $display("run ideal: busy=%0d pass=%0d fail_vec=%0d", bc, pass, fail_vec);

        // Vector 0 expects 0100, so stuck-at-0 on cout[2] fails immediately.
        sa0 = 4'b0100;
        start_pulse();
        wait_done(bc);
        check("sa0_2_busy_cycles", 32'(bc), 32'd3);
        check("sa0_2_pass", 32'(pass), 32'd0);
        check("sa0_2_fail_vec", 32'(fail_vec), 32'd0);
        check("sa0_2_fail_mask", 32'(fail_mask), 32'b0100);
        $display("run sa0[2]: busy=%0d fail_vec=%0d fail_mask=%b", bc, fail_vec, fail_mask);
        sa0 = '0;

        // Vector 1 (a=1000 b=0100 cin=0) expects 1000: first to catch stuck-at-0 on cout[3].
        sa0 = 4'b1000;
        start_pulse();
        wait_done(bc);
        check("sa0_3_busy_cycles", 32'(bc), 32'd6);
        check("sa0_3_fail_vec", 32'(fail_vec), 32'd1);
        check("sa0_3_fail_mask", 32'(fail_mask), 32'b1000);
        $display("run sa0[3]: busy=%0d fail_vec=%0d fail_mask=%b", bc, fail_vec, fail_mask);
        sa0 = '0;

        // Reset during APPLY of vector 10, then a clean rerun.
        start_pulse();
        repeat (3) @(negedge clk);
        check("vec1_dut_a", 32'(m_if.dut_a), 32'b1000);
        check("vec1_dut_b", 32'(m_if.dut_b), 32'b0100);
        check("vec1_dut_cin", 32'(m_if.dut_cin), 32'd0);
        repeat (27) @(negedge clk);
        check("vec10_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_dut_a", 32'(m_if.dut_a), 32'd0);
        check("async_dut_b", 32'(m_if.dut_b), 32'd0);
        check("async_dut_cin", 32'(m_if.dut_cin), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        start_pulse();
        wait_done(bc);
        check("rerun_busy_cycles", 32'(bc), 32'd192);
        check("rerun_pass", 32'(pass), 32'd1);
        $display("run after reset: busy=%0d pass=%0d", bc, pass);

        // start held high: no restart while busy, automatic repeat after done.
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_done(bc);
        check("held_busy_cycles", 32'(bc), 32'd192);
        check("held_pass", 32'(pass), 32'd1);
        @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        wait_done(bc);
        check("held_repeat_busy_cycles", 32'(bc), 32'd192);
        check("held_repeat_pass", 32'(pass), 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("held_done_holds", 32'(done), 32'd1);
        $display("run held start: second busy=%0d pass=%0d", bc, pass);

        // Seed 0x135 drives a=0101 b=0011 cin=1; ideal cout is 0011.
        @(negedge clk) start_g = 1'b1;
        @(negedge clk) start_g = 1'b0;
        check("gold_dut_a", 32'(g_if.dut_a), 32'b0101);
        check("gold_dut_b", 32'(g_if.dut_b), 32'b0011);
        check("gold_dut_cin", 32'(g_if.dut_cin), 32'd1);
        check("gold_cout", 32'(g_if.dut_cout), 32'b0011);
        repeat (3) @(negedge clk);
        check("gold_done", 32'(g_done), 32'd1);
        check("gold_pass", 32'(g_pass), 32'd1);
        $display("run golden seed: done=%0d pass=%0d", g_done, g_pass);

        // One stage, one vector, one settle cycle: done exactly 2 cycles after start.
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        check("small_k0_busy", 32'(s_busy), 32'd1);
        @(negedge clk);
        check("small_k1_done", 32'(s_done), 32'd0);
        @(negedge clk);
        check("small_k2_done", 32'(s_done), 32'd1);
        check("small_k2_pass", 32'(s_pass), 32'd1);
        check("small_k2_busy", 32'(s_busy), 32'd0);
        $display("run minimal: done=%0d pass=%0d", s_done, s_pass);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
